// File: rtl/iq_result_readout_pkg.sv
// rtl/iq_result_readout_pkg.sv - register map, status/ctrl bit positions and FIFO entry type
// Macro RESULT_TIMESTAMP_EN adds a timestamp field to each entry.
package readout_pkg;
  localparam logic [1:0] OFS_STATUS = 2'd0;
  localparam logic [1:0] OFS_I      = 2'd1;
  localparam logic [1:0] OFS_Q      = 2'd2;
  localparam logic [1:0] OFS_TS     = 2'd3;

  localparam int ST_COUNT_LSB = 0;
  localparam int ST_EMPTY     = 16;
  localparam int ST_FULL      = 17;
  localparam int ST_OVF       = 18;
  localparam int ST_DROP_LSB  = 24;
  localparam int ST_VALID     = 32;

  localparam int CTRL_CLR   = 0;
  localparam int CTRL_FLUSH = 1;

  typedef struct packed {
`ifdef RESULT_TIMESTAMP_EN
    logic [31:0] ts;
`endif
    logic [31:0] i;
    logic [31:0] q;
  } result_t;
endpackage

// File: rtl/iq_result_readout_result_fifo.sv
// rtl/iq_result_readout_result_fifo.sv - synchronous FIFO with push/pop/flush and occupancy count
// Flush has priority over push and pop; push into a full FIFO is accepted only with a same-cycle pop.
module result_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok && !flush && !reset) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/iq_result_readout.sv
// rtl/iq_result_readout.sv - buffers I/Q results and serves them as memory-mapped register reads
// Macro RESULT_TIMESTAMP_EN enables a per-entry cycle timestamp readable at offset 3.
module iq_result_readout
  import readout_pkg::*;
#(
  parameter int          DEPTH     = 16,
  parameter logic [13:0] BASE_ADDR = 14'h3F00
) (
  input  logic        clk100,
  input  logic        reset,
  input  logic        iq_valid,
  input  logic [31:0] i_val,
  input  logic [31:0] q_val,
  input  logic [13:0] MEM_sdi_mem_S_address,
  input  logic        MEM_sdi_mem_S_wrEn,
  input  logic [32:0] MEM_sdi_mem_S_wrData,
  input  logic        MEM_sdi_mem_S_rdEn,
  output logic [32:0] MEM_sdi_mem_S_rdData,
  output logic        MEM_sdi_mem_S_rdValid,
  output logic        fifo_empty,
  output logic        fifo_full
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [13:0] ofs_full;
  logic [1:0]  ofs;
  logic        in_win;
  logic        rd_hit;
  logic        wr_hit;
  logic        clr;
  logic        flush;
  logic        pop_req;
  logic        drop_evt;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic [CW-1:0] count;
  result_t     head;
  result_t     wr_entry;
  logic [32:0] rd_mux;
  logic        unused_wr_bits;

  assign ofs_full = MEM_sdi_mem_S_address - BASE_ADDR;
  assign in_win   = (ofs_full < 14'd4);
  assign ofs      = ofs_full[1:0];
  assign rd_hit   = MEM_sdi_mem_S_rdEn & in_win;
  assign wr_hit   = MEM_sdi_mem_S_wrEn & in_win & (ofs == OFS_STATUS);
  assign clr      = wr_hit & MEM_sdi_mem_S_wrData[CTRL_CLR];
  assign flush    = wr_hit & MEM_sdi_mem_S_wrData[CTRL_FLUSH];
  assign pop_req  = rd_hit & (ofs == OFS_Q) & ~fifo_empty;
  // A flushed push is discarded silently rather than counted as a drop
  assign drop_evt = iq_valid & fifo_full & ~pop_req & ~flush;
  assign unused_wr_bits = ^MEM_sdi_mem_S_wrData[32:2];

`ifdef RESULT_TIMESTAMP_EN
  logic [31:0] ts_cnt;
  always_ff @(posedge clk100) begin
    if (reset) ts_cnt <= '0;
    else       ts_cnt <= ts_cnt + 32'd1;
  end
`endif

  always_comb begin
    wr_entry   = '0;
    wr_entry.i = i_val;
    wr_entry.q = q_val;
`ifdef RESULT_TIMESTAMP_EN
    wr_entry.ts = ts_cnt;
`endif
  end

  result_fifo #(.DEPTH(DEPTH), .WIDTH($bits(result_t))) u_fifo (
    .clk     (clk100),
    .reset   (reset),
    .push    (iq_valid),
    .pop     (pop_req),
    .flush   (flush),
    .wr_data (wr_entry),
    .rd_data (head),
    .count   (count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_comb begin
    rd_mux = '0;
    case (ofs)
      OFS_STATUS: begin
        rd_mux[ST_COUNT_LSB +: 16]  = 16'(count);
        rd_mux[ST_EMPTY]            = fifo_empty;
        rd_mux[ST_FULL]             = fifo_full;
        rd_mux[ST_OVF]              = overflow;
        rd_mux[ST_DROP_LSB +: 8]    = drop_cnt;
        rd_mux[ST_VALID]            = 1'b1;
      end
      OFS_I:   if (!fifo_empty) rd_mux = {1'b1, head.i};
      OFS_Q:   if (!fifo_empty) rd_mux = {1'b1, head.q};
`ifdef RESULT_TIMESTAMP_EN
      OFS_TS:  if (!fifo_empty) rd_mux = {1'b1, head.ts};
`endif
      default: rd_mux = '0;
    endcase
  end

  // Clear takes priority over a coincident overflowing push
  always_ff @(posedge clk100) begin
    if (reset) begin
      overflow              <= 1'b0;
      drop_cnt              <= '0;
      MEM_sdi_mem_S_rdData  <= '0;
      MEM_sdi_mem_S_rdValid <= 1'b0;
    end else begin
      if (clr) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end else if (drop_evt) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
      MEM_sdi_mem_S_rdValid <= rd_hit;
      if (rd_hit) MEM_sdi_mem_S_rdData <= rd_mux;
    end
  end
endmodule

// File: tb/tb_iq_result_readout.sv
// tb/tb_iq_result_readout.sv - scoreboard bench for iq_result_readout (honours RESULT_TIMESTAMP_EN)
module tb_iq_result_readout;
  localparam logic [13:0] BASE = 14'h3F00;

  logic        clk100 = 1'b0;
  logic        reset;
  logic        iq_valid;
  logic [31:0] i_val, q_val;
  logic [13:0] addr;
  logic        wr_en, rd_en;
  logic [32:0] wr_data;
  logic [32:0] rd_data;
  logic        rd_valid;
  logic        fifo_empty, fifo_full;

  typedef struct { logic [31:0] i; logic [31:0] q; logic [31:0] ts; } ent_t;
  ent_t sb[$];
  logic        m_ovf;
  logic [7:0]  m_drop;
  logic [32:0] last_data;
  logic [31:0] tb_cyc;
  int errors = 0;
  int checks = 0;

  iq_result_readout dut (
    .clk100                (clk100),
    .reset                 (reset),
    .iq_valid              (iq_valid),
    .i_val                 (i_val),
    .q_val                 (q_val),
    .MEM_sdi_mem_S_address (addr),
    .MEM_sdi_mem_S_wrEn    (wr_en),
    .MEM_sdi_mem_S_wrData  (wr_data),
    .MEM_sdi_mem_S_rdEn    (rd_en),
    .MEM_sdi_mem_S_rdData  (rd_data),
    .MEM_sdi_mem_S_rdValid (rd_valid),
    .fifo_empty            (fifo_empty),
    .fifo_full             (fifo_full)
  );

  always #5 clk100 = ~clk100;

  always @(posedge clk100) begin
    if (reset) tb_cyc <= 32'd0;
    else       tb_cyc <= tb_cyc + 32'd1;
  end

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] status_word();
    logic [15:0] cnt;
    cnt = 16'(sb.size());
    return {1'b1, m_drop, 5'b0, m_ovf, (sb.size() == 16), (sb.size() == 0), cnt};
  endfunction

  // One clock cycle: model the expected response, drive, clock, compare at the falling edge
  task automatic step(input logic iv, input logic [31:0] iv_i, input logic [31:0] iv_q,
                      input logic rd, input logic wr, input logic [13:0] a,
                      input logic [32:0] wd, input logic rst, input string tag);
    logic        win, exp_v, do_pop, do_flush, do_clr;
    logic [13:0] o;
    logic [32:0] exp_d;
    ent_t        e;
    o     = a - BASE;
    win   = (a >= BASE) && (a <= BASE + 14'd3);
    exp_v = rd && win && !rst;
    exp_d = 33'h0;
    if (exp_v) begin
      case (o[1:0])
        2'd0: exp_d = status_word();
        2'd1: if (sb.size() > 0) exp_d = {1'b1, sb[0].i};
        2'd2: if (sb.size() > 0) exp_d = {1'b1, sb[0].q};
        default: begin
`ifdef RESULT_TIMESTAMP_EN
          if (sb.size() > 0) exp_d = {1'b1, sb[0].ts};
`endif
        end
      endcase
    end
    do_pop   = exp_v && (o[1:0] == 2'd2) && (sb.size() > 0);
    do_flush = wr && win && (o[1:0] == 2'd0) && wd[1] && !rst;
    do_clr   = wr && win && (o[1:0] == 2'd0) && wd[0] && !rst;
    e.i = iv_i; e.q = iv_q; e.ts = tb_cyc;
    if (rst) begin
      sb.delete(); m_ovf = 1'b0; m_drop = 8'd0;
    end else begin
      if (do_pop) void'(sb.pop_front());
      if (do_flush) sb.delete();
      else if (iv) begin
        if (sb.size() < 16) sb.push_back(e);
        else begin
          m_ovf = 1'b1;
          if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
        end
      end
      if (do_clr) begin m_ovf = 1'b0; m_drop = 8'd0; end
    end
    if (exp_v) last_data = exp_d;
    if (rst) last_data = 33'h0;
    reset = rst; iq_valid = iv; i_val = iv_i; q_val = iv_q;
    rd_en = rd; wr_en = wr; addr = a; wr_data = wd;
    @(posedge clk100);
    @(negedge clk100);
    reset = 1'b0; iq_valid = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    check({tag, ".rdValid"}, {32'b0, rd_valid}, {32'b0, exp_v});
    check({tag, ".rdData"}, rd_data, last_data);
    check({tag, ".empty"}, {32'b0, fifo_empty}, {32'b0, (sb.size() == 0)});
    check({tag, ".full"}, {32'b0, fifo_full}, {32'b0, (sb.size() == 16)});
  endtask

  task automatic push(input logic [31:0] iv_i, input logic [31:0] iv_q, input string tag);
    step(1'b1, iv_i, iv_q, 1'b0, 1'b0, BASE, 33'h0, 1'b0, tag);
  endtask

  task automatic rd(input logic [13:0] a, input string tag);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, a, 33'h0, 1'b0, tag);
  endtask

  task automatic ctrl(input logic [32:0] wd, input logic iv, input string tag);
    step(iv, 32'hDEAD_0000, 32'hBEEF_0000, 1'b0, 1'b1, BASE, wd, 1'b0, tag);
  endtask

  initial begin
    reset = 1'b1; iq_valid = 1'b0; i_val = '0; q_val = '0;
    addr = '0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    m_ovf = 1'b0; m_drop = 8'd0; last_data = 33'h0;
    repeat (2) @(posedge clk100);
    @(negedge clk100);
    reset = 1'b0;
    check("reset.empty", {32'b0, fifo_empty}, 33'h1);
    check("reset.full", {32'b0, fifo_full}, 33'h0);
    check("reset.rdValid", {32'b0, rd_valid}, 33'h0);
    check("reset.rdData", rd_data, 33'h0);

    push(32'h1, 32'hFFFF_FFFF, "p0");
    rd(BASE + 14'd1, "head_i");
    check("head_i.value", rd_data, 33'h1_0000_0001);
    rd(BASE + 14'd2, "head_q");
    check("head_q.value", rd_data, 33'h1_FFFF_FFFF);
    rd(BASE, "status0");
    check("status0.value", rd_data, 33'h1_0001_0000);

    for (int k = 0; k < 17; k++) push(32'(k + 100), ~32'(k), "fill");
    rd(BASE, "status_ovf");
    check("status_ovf.value", rd_data, 33'h1_0106_0010);
    ctrl(33'h1, 1'b0, "clear");
    rd(BASE, "status_clr");
    step(1'b1, 32'h5555_AAAA, 32'hAAAA_5555, 1'b1, 1'b0, BASE + 14'd2, 33'h0, 1'b0, "push_pop_full");
    rd(BASE, "status_pp");
    check("status_pp.value", rd_data, 33'h1_0002_0010);
    rd(BASE + 14'd1, "next_head");
    check("next_head.value", rd_data, 33'h1_0000_0065);
    for (int k = 0; k < 16; k++) begin
      rd(BASE + 14'd1, "drain_i");
      rd(BASE + 14'd3, "drain_ts");
      rd(BASE + 14'd2, "drain_q");
    end

    rd(BASE + 14'd2, "empty_q");
    rd(BASE, "status_empty");
    rd(14'h0000, "out_of_window");
    rd(14'h3F04, "past_window");
    step(1'b1, 32'h7, 32'h8, 1'b1, 1'b0, BASE + 14'd2, 33'h0, 1'b0, "empty_push_pop");
    rd(BASE + 14'd1, "kept_push");

    for (int k = 0; k < 18; k++) push($urandom, $urandom, "refill");
    ctrl(33'h3, 1'b1, "clr_flush");
    rd(BASE, "status_cf");
    check("status_cf.value", rd_data, 33'h1_0001_0000);

    for (int k = 0; k < 16; k++) push(32'(k), 32'(k), "sat_fill");
    for (int k = 0; k < 260; k++) push(32'hF0F0_0000, 32'h0F0F_0000, "sat");
    rd(BASE, "status_sat");
    check("status_sat.drop", {25'b0, rd_data[31:24]}, 33'hFF);
    ctrl(33'h2, 1'b1, "flush_push");
    rd(BASE, "status_flush");

    push(32'hA, 32'hB, "ts_a");
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, BASE, 33'h0, 1'b0, "gap");
    push(32'hC, 32'hD, "ts_b");
    rd(BASE + 14'd3, "ts_head_a");
    rd(BASE + 14'd2, "ts_pop_a");
    rd(BASE + 14'd3, "ts_head_b");

    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, BASE, 33'h0, 1'b1, "reset_pending");
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, BASE, 33'h0, 1'b0, "after_reset");
    rd(BASE, "status_reset");
    check("status_reset.value", rd_data, 33'h1_0001_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
